// File: rtl/bcd_time_entry_if.sv
// bcd_time_entry_if -- digit entry bus for bcd_time_entry.
//   digit_valid/digit/clear : entry side (master drives)
//   bin/bin_valid/err/busy  : result side (slave drives)
interface bcd_time_entry_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear;
  logic [5:0] bin;
  logic       bin_valid;
  logic       err;
  logic       busy;

  modport master (
    output digit_valid, digit, clear,
    input  bin, bin_valid, err, busy
  );

  modport slave (
    input  digit_valid, digit, clear,
    output bin, bin_valid, err, busy
  );
endinterface

// File: rtl/bcd_time_entry.sv
// bcd_time_entry -- two-digit BCD entry (tens then unit) to 6-bit binary.
//   clk             : clock, rising edge
//   rst             : synchronous active-high reset
//   bus.digit_valid : digit strobe
//   bus.digit       : BCD digit
//   bus.clear       : abort entry in progress
//   bus.bin         : last accepted value (registered)
//   bus.bin_valid   : one-cycle pulse when bin updates
//   bus.err         : one-cycle pulse on rejected entry
//   bus.busy        : tens digit held, unit digit awaited
// Optional: define ENTRY_TIMEOUT_EN to abort with err when the unit digit
// does not arrive within TIMEOUT cycles of the tens digit.
module bcd_time_entry #(
  parameter int unsigned MAX_VAL = 59,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            rst,
  bcd_time_entry_if.slave bus
);

  if (MAX_VAL > 63) begin : g_bad_max
    $error("MAX_VAL out of range 0..63");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_to
    $error("TIMEOUT out of range 1..65535");
  end

  typedef enum logic {IDLE, WAIT_UNIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [5:0] bin_q, bin_d;
  logic       bv_q, bv_d;
  logic       err_q, err_d;
  logic [6:0] value;
  logic       timeout;

  // tens*10 + unit, kept at 7 bits so an oversized sum still fails the compare
  assign value = ({3'b000, tens_q} << 3) + ({3'b000, tens_q} << 1)
               + {3'b000, bus.digit};

`ifdef ENTRY_TIMEOUT_EN
  logic [15:0] cnt_q;

  // Held at zero in IDLE, so it is zero on every entry to WAIT_UNIT.
  always_ff @(posedge clk) begin
    if (rst)                      cnt_q <= '0;
    else if (state_q == IDLE)     cnt_q <= '0;
    else if (!bus.digit_valid)    cnt_q <= cnt_q + 16'd1;
  end

  // A strobe in the terminal-count cycle wins over the timeout.
  assign timeout = (state_q == WAIT_UNIT) && !bus.digit_valid
                && (cnt_q == 16'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tens_q  <= '0;
      bin_q   <= '0;
      bv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      bin_q   <= bin_d;
      bv_q    <= bv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    bin_d   = bin_q;
    bv_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.digit_valid) begin
            if (bus.digit <= 4'd9) begin
              tens_d  = bus.digit;
              state_d = WAIT_UNIT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WAIT_UNIT: begin
          if (bus.digit_valid) begin
            state_d = IDLE;
            if (bus.digit <= 4'd9 && value <= 7'(MAX_VAL)) begin
              bin_d = value[5:0];
              bv_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.bin       = bin_q;
  assign bus.bin_valid = bv_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q == WAIT_UNIT);

endmodule
